data_bus_ctrl: RTL and testbench

- Parametrised successor to the single-device data bus.
- Sits between the pipeline's memory stage and up to NUM_DEV memory-mapped devices (data memory, FP unit, peripherals).
- Decodes the device from the upper address bits and runs one transaction at a time through a registered FSM.
- Supports per-device wait-states, sync-read devices, error reporting and an optional timeout.

---
 rtl/data_bus_pkg.sv | 16 +
 rtl/data_bus_timer.sv | 28 ++
 rtl/data_bus_ctrl.sv | 158 +++++++++++++++
 tb/tb_data_bus_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_bus_pkg.sv
// Shared types and constants for the multi-device data bus controller.
// Consumed by data_bus_ctrl and its testbench.
package data_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDLAT  = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [3:0]  DEV_MEM      = 4'h0;
    localparam logic [3:0]  DEV_FP       = 4'h1;
    localparam logic [15:0] ERR_DATA_DEF = 16'hDEAD;

endpackage

// File: rtl/data_bus_timer.sv
// Access watchdog for data_bus_ctrl: counts enabled cycles since the last clear.
// Only instantiated when DATA_BUS_TIMEOUT_EN is defined.
module data_bus_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // Flags the cycle whose increment brings the count up to LIMIT.
    assign expired = enable && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/data_bus_ctrl.sv
// Multi-device data bus controller: decodes the device from the upper address bits
// and runs one registered transaction at a time. Optional watchdog: DATA_BUS_TIMEOUT_EN.
module data_bus_ctrl
    import data_bus_pkg::*;
#(
    parameter int                  DATA_W       = 16,
    parameter int                  ADDR_W       = 16,
    parameter int                  DEV_SEL_W    = 4,
    parameter int                  NUM_DEV      = 2,
    parameter logic [NUM_DEV-1:0]  SYNC_RD_MASK = 2'b01,
    parameter logic [DATA_W-1:0]   ERR_DATA     = ERR_DATA_DEF,
    parameter int                  TIMEOUT_CYC  = 255
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          ReadData,
    input  logic                          WriteData,
    input  logic [ADDR_W-1:0]             DataAddr,
    input  logic [DATA_W-1:0]             BusIn,
    output logic [DATA_W-1:0]             BusOut,
    output logic                          Waitreq,
    output logic                          BusErr,
    output logic [NUM_DEV-1:0]            DevRead,
    output logic [NUM_DEV-1:0]            DevWrite,
    output logic [ADDR_W-DEV_SEL_W-1:0]   DevAddr,
    output logic [DATA_W-1:0]             DevWdata,
    input  logic [NUM_DEV*DATA_W-1:0]     DevRdata,
    input  logic [NUM_DEV-1:0]            DevWait,
    output state_e                        dbg_state
);

    state_e               state, state_n;
    logic [DEV_SEL_W-1:0] idx_in, idx_q;
    logic                 is_write_q;
    logic                 req, req_bad;
    logic [NUM_DEV-1:0]   req_onehot;
    logic                 sel_wait, sel_sync;
    logic [DATA_W-1:0]    sel_rdata;
    logic                 timeout;

    assign req       = ReadData | WriteData;
    assign idx_in    = DataAddr[ADDR_W-1 -: DEV_SEL_W];
    assign req_bad   = (int'(idx_in) >= NUM_DEV) || (ReadData && WriteData);
    assign Waitreq   = req && (state != DONE);
    assign dbg_state = state;

    // Decode the incoming index for strobes, and the latched index for device responses.
    always_comb begin
        req_onehot = '0;
        sel_wait   = 1'b0;
        sel_sync   = 1'b0;
        sel_rdata  = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (idx_in == DEV_SEL_W'(i)) begin
                req_onehot[i] = 1'b1;
            end
            if (idx_q == DEV_SEL_W'(i)) begin
                sel_wait  = DevWait[i];
                sel_sync  = SYNC_RD_MASK[i];
                sel_rdata = DevRdata[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef DATA_BUS_TIMEOUT_EN
    data_bus_timer #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timer (
        .clk     (Clock),
        .rst_n   (Reset),
        .clear   (state == IDLE),
        .enable  ((state == ACCESS) || (state == RDLAT)),
        .expired (timeout)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (req) begin
                    state_n = req_bad ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                if (sel_wait) begin
                    if (timeout) begin
                        state_n = DONE;
                    end
                end else begin
                    state_n = (is_write_q || !sel_sync) ? DONE : RDLAT;
                end
            end
            RDLAT:   state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state      <= IDLE;
            BusOut     <= '0;
            BusErr     <= 1'b0;
            DevRead    <= '0;
            DevWrite   <= '0;
            DevAddr    <= '0;
            DevWdata   <= '0;
            idx_q      <= '0;
            is_write_q <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (req) begin
                        idx_q      <= idx_in;
                        DevAddr    <= DataAddr[ADDR_W-DEV_SEL_W-1:0];
                        DevWdata   <= BusIn;
                        is_write_q <= WriteData;
                        if (req_bad) begin
                            BusErr <= 1'b1;
                            BusOut <= ERR_DATA;
                        end else begin
                            DevRead  <= ReadData  ? req_onehot : '0;
                            DevWrite <= WriteData ? req_onehot : '0;
                        end
                    end
                end
                ACCESS: begin
                    if (state_n != ACCESS) begin
                        DevRead  <= '0;
                        DevWrite <= '0;
                        // Leaving while the device still waits can only be a watchdog abort.
                        if (sel_wait) begin
                            BusErr <= 1'b1;
                            BusOut <= ERR_DATA;
                        end else if (is_write_q) begin
                            BusErr <= 1'b0;
                        end else if (!sel_sync) begin
                            BusErr <= 1'b0;
                            BusOut <= sel_rdata;
                        end
                    end
                end
                RDLAT: begin
                    BusErr <= 1'b0;
                    BusOut <= sel_rdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Self-checking bench for data_bus_ctrl with a behavioural two-device model
// (dev0: synchronous-read memory, dev1: asynchronous register with wait-states).
module tb_data_bus_ctrl;
    import data_bus_pkg::*;

    localparam int NUM_DEV = 2;
    localparam int TMO     = 8;

    logic                 Clock = 1'b0;
    logic                 Reset = 1'b0;
    logic                 ReadData = 1'b0;
    logic                 WriteData = 1'b0;
    logic [15:0]          DataAddr = '0;
    logic [15:0]          BusIn = '0;
    logic [15:0]          BusOut;
    logic                 Waitreq;
    logic                 BusErr;
    logic [NUM_DEV-1:0]   DevRead;
    logic [NUM_DEV-1:0]   DevWrite;
    logic [11:0]          DevAddr;
    logic [15:0]          DevWdata;
    logic [31:0]          DevRdata;
    logic [NUM_DEV-1:0]   DevWait;
    state_e               dbg_state;

    data_bus_ctrl #(
        .TIMEOUT_CYC (TMO)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .ReadData  (ReadData),
        .WriteData (WriteData),
        .DataAddr  (DataAddr),
        .BusIn     (BusIn),
        .BusOut    (BusOut),
        .Waitreq   (Waitreq),
        .BusErr    (BusErr),
        .DevRead   (DevRead),
        .DevWrite  (DevWrite),
        .DevAddr   (DevAddr),
        .DevWdata  (DevWdata),
        .DevRdata  (DevRdata),
        .DevWait   (DevWait),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 Clock = ~Clock;

    // ---------------- device model ----------------
    int          act_cnt [NUM_DEV];
    int          wait_cfg [NUM_DEV];
    logic [15:0] dev_mem [256];
    logic [15:0] dev1_data = '0;
    logic        rd_valid0 = 1'b0;

    always @(posedge Clock) begin
        for (int i = 0; i < NUM_DEV; i++) begin
            act_cnt[i] <= (DevRead[i] | DevWrite[i]) ? act_cnt[i] + 1 : 0;
        end
        rd_valid0 <= DevRead[0] && !DevWait[0];
        if (DevWrite[0] && !DevWait[0]) dev_mem[DevAddr[7:0]] <= DevWdata;
    end

    always_comb begin
        for (int i = 0; i < NUM_DEV; i++) begin
            DevWait[i] = (DevRead[i] | DevWrite[i]) && (act_cnt[i] < wait_cfg[i]);
        end
        DevRdata[15:0]  = rd_valid0  ? dev_mem[DevAddr[7:0]] : 16'h0BAD;
        DevRdata[31:16] = DevWait[1] ? 16'h0BAD : dev1_data;
    end

    // ---------------- scoreboard ----------------
    logic [24:0] exp_q[$];
    logic [15:0] model_mem [256];
    logic [15:0] last_out = '0;
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_txn(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [15:0] wdata, input int wcyc, input logic [15:0] d1,
                          input bit scramble, input bit expect_tmo);
        int          dev;
        int          lat;
        int          cyc;
        bit          done;
        logic        err;
        logic [15:0] exp_d;
        logic [24:0] e;
        logic [1:0]  onehot;

        dev    = int'(addr[15:12]);
        err    = (dev >= NUM_DEV) || (rd && wr) || expect_tmo;
        onehot = (dev == 0) ? 2'b01 : 2'b10;
        if (err) begin
            lat   = expect_tmo ? TMO + 1 : 1;
            exp_d = 16'hDEAD;
        end else if (wr) begin
            lat   = 2 + wcyc;
            exp_d = last_out;
            if (dev == 0) model_mem[addr[7:0]] = wdata;
        end else if (dev == 0) begin
            lat   = 3 + wcyc;
            exp_d = model_mem[addr[7:0]];
        end else begin
            lat   = 2 + wcyc;
            exp_d = d1;
        end
        last_out = exp_d;
        exp_q.push_back({8'(lat), err, exp_d});
        if (dev < NUM_DEV) wait_cfg[dev] = wcyc;
        dev1_data = d1;

        @(negedge Clock);
        ReadData  = rd;
        WriteData = wr;
        DataAddr  = addr;
        BusIn     = wdata;
        cyc  = 0;
        done = 0;
        while (!done && cyc < 60) begin
            @(posedge Clock);
            cyc++;
            @(negedge Clock);
            if (cyc == 1) begin
                if (err && !expect_tmo) begin
                    check_eq("no_strobe", 32'({DevRead, DevWrite}), 32'd0);
                end else begin
                    check_eq("dev_read",  32'(DevRead),  32'(rd ? onehot : 2'b00));
                    check_eq("dev_write", 32'(DevWrite), 32'(wr ? onehot : 2'b00));
                    check_eq("dev_addr",  32'(DevAddr),  32'(addr[11:0]));
                    if (wr) check_eq("dev_wdata", 32'(DevWdata), 32'(wdata));
                end
                if (scramble) begin
                    DataAddr = ~addr;
                    BusIn    = ~wdata;
                end
            end
            if (scramble && cyc == 3) begin
                check_eq("latched_addr",  32'(DevAddr),  32'(addr[11:0]));
                check_eq("latched_wdata", 32'(DevWdata), 32'(wdata));
            end
            if (!Waitreq) done = 1;
        end
        if (!done) check_eq("wait_bound", 32'(cyc), 32'd0);
        e = exp_q.pop_front();
        check_eq("latency", 32'(cyc),    32'(e[24:17]));
        check_eq("bus_err", 32'(BusErr), 32'(e[16]));
        check_eq("bus_out", 32'(BusOut), 32'(e[15:0]));
        ReadData  = 1'b0;
        WriteData = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          sel;
        logic [15:0] a;
        for (int i = 0; i < 256; i++) begin
            dev_mem[i]   = '0;
            model_mem[i] = '0;
        end
        for (int i = 0; i < NUM_DEV; i++) begin
            act_cnt[i]  = 0;
            wait_cfg[i] = 0;
        end

        Reset = 1'b0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        check_eq("rst_bus_out", 32'(BusOut),   32'd0);
        check_eq("rst_bus_err", 32'(BusErr),   32'd0);
        check_eq("rst_strobes", 32'({DevRead, DevWrite}), 32'd0);
        check_eq("rst_dev_addr", 32'(DevAddr), 32'd0);
        check_eq("rst_wdata",   32'(DevWdata), 32'd0);
        check_eq("rst_waitreq", 32'(Waitreq),  32'd0);
        check_eq("rst_state",   32'(dbg_state), 32'(IDLE));

        do_txn(1'b0, 1'b1, 16'h0005, 16'h1234, 0, 16'h0000, 1'b0, 1'b0);
        do_txn(1'b1, 1'b0, 16'h0005, 16'h0000, 0, 16'h0000, 1'b0, 1'b0);
        do_txn(1'b1, 1'b0, 16'h1002, 16'h0000, 4, 16'hBEEF, 1'b1, 1'b0);
        do_txn(1'b1, 1'b0, 16'h7000, 16'h0000, 0, 16'h0000, 1'b0, 1'b0);
        do_txn(1'b1, 1'b1, 16'h0005, 16'h5A5A, 0, 16'h0000, 1'b0, 1'b0);
        do_txn(1'b0, 1'b1, 16'h1003, 16'h4321, 2, 16'h0000, 1'b1, 1'b0);
        do_txn(1'b1, 1'b0, 16'hF000, 16'h0000, 0, 16'h0000, 1'b0, 1'b0);
        do_txn(1'b1, 1'b0, 16'h0005, 16'h0000, 1, 16'h0000, 1'b0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            sel = $urandom_range(0, 4);
            a   = 16'($urandom_range(0, 15));
            case (sel)
                0: do_txn(1'b0, 1'b1, a, 16'($urandom), $urandom_range(0, 3), 16'h0, 1'b0, 1'b0);
                1: do_txn(1'b1, 1'b0, a, 16'h0, $urandom_range(0, 3), 16'h0, 1'b0, 1'b0);
                2: do_txn(1'b1, 1'b0, a | 16'h1000, 16'h0, $urandom_range(0, 3),
                          16'($urandom), 1'b0, 1'b0);
                3: do_txn($urandom_range(0, 1) == 1, 1'b1, a | 16'(($urandom_range(2, 15)) << 12),
                          16'($urandom), 0, 16'h0, 1'b0, 1'b0);
                default: do_txn(1'b1, 1'b1, a, 16'($urandom), 0, 16'h0, 1'b0, 1'b0);
            endcase
        end

`ifdef DATA_BUS_TIMEOUT_EN
        do_txn(1'b1, 1'b0, 16'h1004, 16'h0000, 1000, 16'h5555, 1'b0, 1'b1);
        do_txn(1'b1, 1'b0, 16'h1004, 16'h0000, 1, 16'h6666, 1'b0, 1'b0);
`endif

        // Reset in the middle of a long dev1 access.
        wait_cfg[1] = 20;
        @(negedge Clock);
        ReadData = 1'b1;
        DataAddr = 16'h1001;
        repeat (3) @(negedge Clock);
        check_eq("pre_rst_state", 32'(dbg_state), 32'(ACCESS));
        Reset = 1'b0;
        @(negedge Clock);
        check_eq("mid_rst_strobes", 32'({DevRead, DevWrite}), 32'd0);
        check_eq("mid_rst_state",   32'(dbg_state), 32'(IDLE));
        check_eq("mid_rst_bus_out", 32'(BusOut), 32'd0);
        check_eq("mid_rst_bus_err", 32'(BusErr), 32'd0);
        Reset    = 1'b1;
        ReadData = 1'b0;
        last_out = '0;
        repeat (2) @(negedge Clock);

        do_txn(1'b1, 1'b0, 16'h1009, 16'h0000, 0, 16'hC0DE, 1'b0, 1'b0);
        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
